// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit 7-segment scanner with double-buffered BCD load.
// Latency: a load in IDLE drives the hundreds slot from the next cycle; a load during a scan takes effect at the next frame boundary.
// Backpressure: none; load is a single-cycle strobe that is always accepted (last one before a boundary wins).
module bcd_display_scanner #(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] a3_a0,
  input  logic [3:0] b3_b0,
  input  logic [3:0] c3_c0,
  output logic [6:0] seg6_seg0,
  output logic [2:0] an2_an0,
  output logic       frame_end,
  output logic       pend
);

  // Counter is wide enough for 0..SCAN_DIV-1; keep at least one bit for SCAN_DIV=1.
  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_D2   = 2'd1,
    S_D1   = 2'd2,
    S_D0   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   disp_q, disp_d;   // {hundreds, tens, units} currently shown
  logic [11:0]   pdat_q, pdat_d;   // value waiting for the next frame boundary
  logic          pend_q, pend_d;

  logic [11:0]   in_dat;
  logic          slot_last;
  logic          boundary;

  assign in_dat    = {a3_a0, b3_b0, c3_c0};
  assign slot_last = (cnt_q == CNT_LAST);
  assign boundary  = (state_q == S_D0) && slot_last;

  // Map a BCD digit to segments (bit0=a .. bit6=g); non-decimal codes show a dash.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // State, slot counter and both display buffers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      disp_q  <= '0;
      pdat_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pdat_q  <= pdat_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: slot sequencing plus the load/pending/boundary buffer rules.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pdat_d  = pdat_q;
    pend_d  = pend_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          disp_d  = in_dat;
          state_d = S_D2;
          cnt_d   = '0;
        end
      end
      S_D2: begin
        if (slot_last) begin
          state_d = S_D1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_D1: begin
        if (slot_last) begin
          state_d = S_D0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_D0: begin
        if (slot_last) begin
          state_d = S_D2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Buffer handling while scanning. A load coinciding with the boundary
    // wins over anything pending, which is then dropped.
    if (state_q != S_IDLE) begin
      if (boundary) begin
        if (load) begin
          disp_d = in_dat;
          pend_d = 1'b0;
        end else if (pend_q) begin
          disp_d = pdat_q;
          pend_d = 1'b0;
        end
      end else if (load) begin
        pdat_d = in_dat;
        pend_d = 1'b1;
      end
    end
  end

  logic [3:0] dig_h, dig_t, dig_u;
  logic       blank_h, blank_t;

  assign dig_h   = disp_q[11:8];
  assign dig_t   = disp_q[7:4];
  assign dig_u   = disp_q[3:0];
  // Only a true zero blanks; invalid codes always show their dash.
  assign blank_h = BLANK_LZ && (dig_h == 4'd0);
  assign blank_t = blank_h && (dig_t == 4'd0);

  // Moore output decode from state, counter and display register only.
  always_comb begin
    an2_an0   = 3'b000;
    seg6_seg0 = 7'h00;
    frame_end = 1'b0;
    case (state_q)
      S_D2: begin
        an2_an0   = 3'b100;
        seg6_seg0 = blank_h ? 7'h00 : seg_of(dig_h);
      end
      S_D1: begin
        an2_an0   = 3'b010;
        seg6_seg0 = blank_t ? 7'h00 : seg_of(dig_t);
      end
      S_D0: begin
        an2_an0   = 3'b001;
        seg6_seg0 = seg_of(dig_u);
        frame_end = slot_last;
      end
      default: begin
        an2_an0   = 3'b000;
        seg6_seg0 = 7'h00;
      end
    endcase
  end

  assign pend = pend_q;

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Time-multiplexed driver for a 3-digit common-anode-select 7-segment display.
- Consumes the three BCD digits produced by the 8-bit binary-to-BCD converter (hundreds, tens, units) and scans them one digit at a time.
- Provides leading-zero blanking, an invalid-digit indication, and double-buffered loading, so a new value is shown only at a frame boundary.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays selected; legal range 1..256.
BLANK_LZ, 1, 1 enables leading-zero blanking; 0 displays all digits.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
load  in  1  single-cycle strobe: sample a3_a0/b3_b0/c3_c0 this edge.
a3_a0  in  4  hundreds BCD digit.
b3_b0  in  4  tens BCD digit.
c3_c0  in  4  units BCD digit.
seg6_seg0  out  7  segment drive, active-high; bit0=a ... bit6=g.
an2_an0  out  3  one-hot digit select, active-high; an2=hundreds, an0=units.
frame_end  out  1  high during the last cycle of the units-digit slot.
pend  out  1  a loaded value is waiting for the next frame boundary.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (any state, any count):
  - FSM goes to IDLE; counter=0; display and pending registers=0; pend=0.
  - seg6_seg0=0, an2_an0=000, frame_end=0 from the cycle after the reset edge.
- FSM states: IDLE, D2 (hundreds), D1 (tens), D0 (units).
- Outputs are Moore: decoded from state, counter and display register only. There is no combinational path from inputs to outputs.
- IDLE:
  - an2_an0=000, seg6_seg0=0.
  - load=1 at an edge: display register <= {a,b,c}; next state D2 with counter=0.
- D2/D1/D0:
  - an2_an0 is 100/010/001 respectively.
  - Counter runs 0..SCAN_DIV-1; at count SCAN_DIV-1 the state advances D2->D1->D0->D2 and the counter clears.
  - Each digit is therefore held exactly SCAN_DIV cycles; a frame is 3*SCAN_DIV cycles.
- frame_end=1 exactly when state=D0 and counter=SCAN_DIV-1.
- Loading during a scan:
  - load=1 while state is not IDLE and frame_end=0: pending register <= inputs, pend<=1.
  - A second load before the boundary overwrites the pending value; last one wins.
- Frame boundary (edge where frame_end=1):
  - If load=1 at this edge: display <= inputs directly; pend<=0. The stale pending value is discarded.
  - Else if pend=1: display <= pending; pend<=0.
  - Else display is unchanged.
  - In all cases the next state is D2.
- Never returns to IDLE except by reset.
- Segment decode (digit value -> seg6_seg0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10..15 -> 40 (dash, g only).
- Leading-zero blanking (BLANK_LZ=1):
  - Hundreds slot shows seg=00 if hundreds==0.
  - Tens slot shows seg=00 if hundreds==0 and tens==0.
  - The units digit is never blanked.
  - an2_an0 still selects the blanked slot.
  - Invalid digits are never blanked (e.g. hundreds=A shows 40).
- SCAN_DIV=1: each state lasts one cycle; frame_end repeats every 3 cycles; all boundary rules unchanged.
- Latency: load in IDLE at edge k -> an2_an0=100 with the new hundreds segments from edge k until edge k+SCAN_DIV.

Test Plan:
- Reset: hold reset 3 cycles, then release with load=0 for 20 cycles -> seg6_seg0=00, an2_an0=000, pend=0, frame_end=0 throughout.
- SCAN_DIV=2. Load 2,5,5 in IDLE -> next cycle:
  - an=100/seg=5B for 2 cycles, an=010/seg=6D for 2 cycles, an=001/seg=6D for 2 cycles.
  - frame_end high on the 6th cycle only; pattern repeats.
- Blanking, SCAN_DIV=2, BLANK_LZ=1:
  - Load 0,0,7 -> D2 seg=00, D1 seg=00, D0 seg=07.
  - Load 0,4,0 -> D2 seg=00, D1 seg=66, D0 seg=3F.
  - BLANK_LZ=0 with 0,0,7 -> 3F, 3F, 07.
- Double buffering, SCAN_DIV=2:
  - Displaying 2,5,5; load 1,2,8 during D1 -> pend=1; current frame still shows 6D in D1/D0.
  - After frame_end the next frame shows 06, 5B, 7F with pend=0.
- Boundary collision:
  - pend=1 holding 1,2,8; load 9,9,9 on the frame_end cycle -> next frame shows 6F, 6F, 6F; pend=0.
  - Load 0,0,B -> D0 seg=40.
  - Assert reset during D1 -> next cycle IDLE, an=000, seg=00, pend=0.
